// File: rtl/pixel_mem_pkg.sv
// rtl/pixel_mem_pkg.sv - shared types and sizes for the pixel memory read arbiter
package pixel_mem_pkg;

   localparam int ADDR_W    = 20;
   localparam int DATA_W    = 32;
   localparam int MEM_DEPTH = 307200;

   typedef enum logic {
      PORT_CPU = 1'b0,
      PORT_VGA = 1'b1
   } port_id_t;

   typedef struct packed {
      logic     valid;
      port_id_t id;
      logic     oor;
   } rd_stage_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with last-granted pointer
module rr_arbiter2
   import pixel_mem_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   port_id_t last_q;
   port_id_t last_d;

   always_comb begin
      gnt    = 2'b00;
      last_d = last_q;
      if (req[0] && req[1]) begin
         // contention goes to whichever port was not served most recently
         gnt = (last_q == PORT_CPU) ? 2'b10 : 2'b01;
      end else begin
         gnt = req;
      end
      if (gnt[0]) begin
         last_d = PORT_CPU;
      end else if (gnt[1]) begin
         last_d = PORT_VGA;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= PORT_VGA;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/pixel_mem_arbiter.sv
// rtl/pixel_mem_arbiter.sv - CPU/display arbiter for the single pixel memory read port
module pixel_mem_arbiter #(
   parameter int ADDR_W    = 20,
   parameter int DATA_W    = 32,
   parameter int MEM_DEPTH = 307200
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_err,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_gnt,
   output logic              vga_rvalid,
   output logic [DATA_W-1:0] vga_rdata,
   output logic              vga_err,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata
);

   import pixel_mem_pkg::*;

   logic [1:0]        req;
   logic [1:0]        gnt;
   logic [ADDR_W-1:0] sel_addr;
   logic              sel_oor;

   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   rd_stage_t         a_q, a_d;
   logic              cpu_rvalid_q, cpu_rvalid_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic              cpu_err_q, cpu_err_d;
   logic              vga_rvalid_q, vga_rvalid_d;
   logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
   logic              vga_err_q, vga_err_d;

   assign req = {vga_req, cpu_req};

   rr_arbiter2 u_rr (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .gnt   (gnt)
   );

   always_comb begin
      sel_addr = gnt[1] ? vga_addr : cpu_addr;
      sel_oor  = (64'(sel_addr) >= 64'(MEM_DEPTH));

      mem_addr_d = mem_addr_q;
      a_d.valid  = |gnt;
      a_d.id     = gnt[1] ? PORT_VGA : PORT_CPU;
      a_d.oor    = (|gnt) && sel_oor;
      // out-of-range reads park the memory on address 0
      if (|gnt) begin
         mem_addr_d = sel_oor ? '0 : sel_addr;
      end

      cpu_rvalid_d = a_q.valid && (a_q.id == PORT_CPU);
      cpu_err_d    = cpu_rvalid_d && a_q.oor;
      cpu_rdata_d  = cpu_rdata_q;
      if (cpu_rvalid_d) begin
         cpu_rdata_d = a_q.oor ? '0 : mem_rdata;
      end

      vga_rvalid_d = a_q.valid && (a_q.id == PORT_VGA);
      vga_err_d    = vga_rvalid_d && a_q.oor;
      vga_rdata_d  = vga_rdata_q;
      if (vga_rvalid_d) begin
         vga_rdata_d = a_q.oor ? '0 : mem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr_q   <= '0;
         a_q          <= '{valid: 1'b0, id: PORT_CPU, oor: 1'b0};
         cpu_rvalid_q <= 1'b0;
         cpu_rdata_q  <= '0;
         cpu_err_q    <= 1'b0;
         vga_rvalid_q <= 1'b0;
         vga_rdata_q  <= '0;
         vga_err_q    <= 1'b0;
      end else begin
         mem_addr_q   <= mem_addr_d;
         a_q          <= a_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         cpu_rdata_q  <= cpu_rdata_d;
         cpu_err_q    <= cpu_err_d;
         vga_rvalid_q <= vga_rvalid_d;
         vga_rdata_q  <= vga_rdata_d;
         vga_err_q    <= vga_err_d;
      end
   end

   assign cpu_gnt    = gnt[0];
   assign vga_gnt    = gnt[1];
   assign mem_addr   = mem_addr_q;
   assign cpu_rvalid = cpu_rvalid_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign cpu_err    = cpu_err_q;
   assign vga_rvalid = vga_rvalid_q;
   assign vga_rdata  = vga_rdata_q;
   assign vga_err    = vga_err_q;

endmodule

// File: tb/tb_pixel_mem_arbiter.sv
// tb/tb_pixel_mem_arbiter.sv - randomized self-checking bench for pixel_mem_arbiter
module tb_pixel_mem_arbiter;

   localparam int DEPTH = 307200;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req, vga_req;
   logic [19:0] cpu_addr, vga_addr;
   logic        cpu_gnt, vga_gnt;
   logic        cpu_rvalid, vga_rvalid;
   logic [31:0] cpu_rdata, vga_rdata;
   logic        cpu_err, vga_err;
   logic [19:0] mem_addr;
   logic [31:0] mem_rdata;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      int          due;
      bit          port;
      logic [19:0] addr;
   } exp_t;

   exp_t        q[$];
   int          cyc;
   bit          last_port;
   logic [19:0] exp_mem_addr;
   logic [31:0] last_rdata [2];
   bit          cpu_pend, vga_pend;
   bit          acc_c, acc_v;

   always #5 clk = ~clk;

   function automatic logic [7:0] pix(input logic [19:0] a);
      logic [7:0] t;
      t = a[7:0] * 8'd37;
      t = t + a[15:8] * 8'd11;
      t = t + {4'b0, a[19:16]};
      return t + 8'hA5;
   endfunction

   assign mem_rdata = {24'h0, pix(mem_addr)};

   pixel_mem_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cpu_req    (cpu_req),
      .cpu_addr   (cpu_addr),
      .cpu_gnt    (cpu_gnt),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .cpu_err    (cpu_err),
      .vga_req    (vga_req),
      .vga_addr   (vga_addr),
      .vga_gnt    (vga_gnt),
      .vga_rvalid (vga_rvalid),
      .vga_rdata  (vga_rdata),
      .vga_err    (vga_err),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      last_port     = 1'b1;
      exp_mem_addr  = '0;
      last_rdata[0] = '0;
      last_rdata[1] = '0;
      cpu_pend      = 1'b0;
      vga_pend      = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_cpu_gnt"}, {31'b0, cpu_gnt}, 32'(cpu_req));
      check_eq({tag, "_outs"}, {26'b0, cpu_rvalid, cpu_err, vga_rvalid, vga_err, 2'b0}, 32'h0);
      check_eq({tag, "_cpu_rdata"}, cpu_rdata, 32'h0);
      check_eq({tag, "_vga_rdata"}, vga_rdata, 32'h0);
      check_eq({tag, "_mem_addr"}, {12'b0, mem_addr}, 32'h0);
   endtask

   // One clock cycle: drive, check outputs against the model, then advance the model
   task automatic step(input bit cr, input logic [19:0] ca, input bit vr, input logic [19:0] va);
      bit          rv [2];
      bit          er [2];
      bit          eg_c, eg_v;
      exp_t        e;
      @(negedge clk);
      cpu_req  = cr;
      cpu_addr = ca;
      vga_req  = vr;
      vga_addr = va;
      #1;
      rv[0] = 0; rv[1] = 0; er[0] = 0; er[1] = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         rv[e.port] = 1;
         er[e.port] = (int'(e.addr) >= DEPTH);
         last_rdata[e.port] = er[e.port] ? 32'h0 : {24'h0, pix(e.addr)};
      end
      check_eq("cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, rv[0]});
      check_eq("cpu_err",    {31'b0, cpu_err},    {31'b0, er[0]});
      check_eq("cpu_rdata",  cpu_rdata, last_rdata[0]);
      check_eq("vga_rvalid", {31'b0, vga_rvalid}, {31'b0, rv[1]});
      check_eq("vga_err",    {31'b0, vga_err},    {31'b0, er[1]});
      check_eq("vga_rdata",  vga_rdata, last_rdata[1]);
      check_eq("mem_addr",   {12'b0, mem_addr}, {12'b0, exp_mem_addr});

      if (cr && vr) begin
         eg_c = (last_port == 1'b1);
         eg_v = !eg_c;
      end else begin
         eg_c = cr;
         eg_v = vr;
      end
      check_eq("cpu_gnt", {31'b0, cpu_gnt}, {31'b0, eg_c});
      check_eq("vga_gnt", {31'b0, vga_gnt}, {31'b0, eg_v});
      if (eg_c) begin
         q.push_back('{due: cyc + 2, port: 1'b0, addr: ca});
         exp_mem_addr = (int'(ca) >= DEPTH) ? 20'h0 : ca;
         last_port    = 1'b0;
      end
      if (eg_v) begin
         q.push_back('{due: cyc + 2, port: 1'b1, addr: va});
         exp_mem_addr = (int'(va) >= DEPTH) ? 20'h0 : va;
         last_port    = 1'b1;
      end
      acc_c    = eg_c;
      acc_v    = eg_v;
      cpu_pend = cr && !eg_c;
      vga_pend = vr && !eg_v;
      cyc++;
   endtask

   // A pending (ungranted) request keeps its address; otherwise take the new one
   task automatic drive(input bit wc, input logic [19:0] nca, input bit wv, input logic [19:0] nva);
      bit          cr, vr;
      logic [19:0] ca, va;
      cr = cpu_pend ? 1'b1 : wc;
      ca = cpu_pend ? cpu_addr : nca;
      vr = vga_pend ? 1'b1 : wv;
      va = vga_pend ? vga_addr : nva;
      step(cr, ca, vr, va);
   endtask

   function automatic logic [19:0] rand_addr();
      case ($urandom_range(0, 5))
         0: return 20'(DEPTH - 1);
         1: return 20'(DEPTH);
         2: return 20'hFFFFF;
         default: return 20'($urandom_range(0, 20'hFFFFF));
      endcase
   endfunction

   initial begin
      logic [19:0] cn, vn;
      rst_n    = 1'b0;
      cpu_req  = 1'b0;
      vga_req  = 1'b0;
      cpu_addr = '0;
      vga_addr = '0;
      cyc      = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      step(0, 0, 0, 0);
      step(1, 20'h0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      check_eq("a5_direct", cpu_rdata, 32'h000000A5);

      cn = 20'd100;
      vn = 20'd200;
      for (int i = 0; i < 10; i++) begin
         drive(1, cn, 1, vn);
         if (acc_c) cn++;
         if (acc_v) vn++;
      end
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);

      drive(0, 0, 1, 20'd307199);
      drive(0, 0, 1, 20'd307200);
      drive(1, 20'd5, 1, 20'hFFFFF);
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);

      for (int i = 0; i < 10; i++) drive(0, 0, 1, 20'(1000 + i * 7));
      for (int i = 0; i < 10; i++) drive(1, 20'(2000 + i * 3), 0, 0);
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);

      step(1, 20'd42, 0, 0);
      cpu_req = 1'b0;
      vga_req = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      cyc++;
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);

      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 3) != 0), rand_addr(), ($urandom_range(0, 3) != 0), rand_addr());
      end
      cpu_pend = 1'b0;
      vga_pend = 1'b0;
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/pixel_mem_arbiter.md
Name: pixel_mem_arbiter

Overview:
- Shares the single combinational read port of the 640x480 8-bit pixel data memory between two requesters: CPU load port (port 0) and display scan-out engine (port 1).
- Performs round-robin arbitration, registers the memory address and the returned pixel, and range-checks addresses.
- Sits between the processor memory stage / VGA controller and the pixel data memory.

Parameters:
- ADDR_W, 20, byte address width of the pixel memory
- DATA_W, 32, read data width (pixel byte zero-extended)
- MEM_DEPTH, 307200, number of valid pixel addresses (640*480)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU read request; held until granted
- cpu_addr  in  ADDR_W  CPU read address
- cpu_gnt  out  1  CPU request accepted this cycle (combinational)
- cpu_rvalid  out  1  CPU read data valid, one-cycle pulse
- cpu_rdata  out  DATA_W  CPU read data
- cpu_err  out  1  accompanies cpu_rvalid; address was out of range
- vga_req  in  1  display read request; held until granted
- vga_addr  in  ADDR_W  display read address
- vga_gnt  out  1  display request accepted this cycle (combinational)
- vga_rvalid  out  1  display read data valid, one-cycle pulse
- vga_rdata  out  DATA_W  display read data
- vga_err  out  1  accompanies vga_rvalid; address was out of range
- mem_addr  out  ADDR_W  registered address to the pixel memory
- mem_rdata  in  DATA_W  combinational memory result for mem_addr

Behaviour:
- Reset: all outputs 0; mem_addr 0; round-robin pointer favours CPU; pipeline valid bits 0. Reset is asynchronous, so an in-flight read is dropped and no rvalid fires afterwards for it.
- Arbitration (combinational per cycle):
  - Only one request: it is granted.
  - Both requests: grant goes to the port not granted most recently (pointer = last granted id).
  - Pointer updates only on a grant.
  - No grant when neither port requests.
- A request is accepted in cycle N when req=1 and gnt=1. The requester must hold addr stable while req=1 and gnt=0.
- Stage A, edge ending cycle N: mem_addr <= granted addr; a_valid <= 1; a_id <= port; a_oor <= (addr >= MEM_DEPTH).
  - Out-of-range accept: mem_addr <= 0 so the memory is never indexed past its end.
- Stage B, edge ending cycle N+1:
  - If a_valid: the owning port's rvalid <= 1.
  - rdata <= a_oor ? 0 : mem_rdata.
  - err <= a_oor.
  - The other port's rvalid <= 0.
- Fixed latency: rvalid asserted in cycle N+2 after accept in cycle N.
- Throughput: one accept per cycle, fully pipelined; no backpressure. Requesters must accept rvalid when it fires.
- Hold behaviour:
  - rdata holds its last value when rvalid=0.
  - err is 0 whenever rvalid=0.
  - mem_addr holds its last value when idle.
- Back-to-back accepts alternate ports while both request. A port is never starved for more than one cycle.
- Address MEM_DEPTH-1 (307199) is valid. MEM_DEPTH and above, up to 2^20-1, return err=1 and rdata=0.

Decomposition:
- Package pixel_mem_pkg holds:
  - MEM_DEPTH, ADDR_W, DATA_W
  - typedef enum logic {PORT_CPU=0, PORT_VGA=1} port_id_t
  - typedef struct {valid, id, oor} rd_stage_t
- One natural sub-module: rr_arbiter2, a 2-way round-robin grant with pointer register, clk/rst_n.
- Pipeline registers stay in the top.

Test Plan:
- Reset then idle → all outputs 0, mem_addr=0. Assert rst_n=0 mid-read → no rvalid after release.
- cpu_req=1, addr=0 with memory byte 8'hA5 → cpu_gnt in cycle 0, mem_addr=0 after edge, cpu_rvalid=1 and cpu_rdata=32'h000000A5 in cycle 2, cpu_err=0.
- Both ports request continuously (cpu 100.., vga 200..) → grants alternate CPU, VGA, CPU, ... starting with CPU after reset. rvalid pulses alternate with 2-cycle latency; each port receives its own address's data.
- vga_addr=307199 → valid data, err=0. vga_addr=307200 and 20'hFFFFF → vga_err=1, vga_rdata=0, mem_addr=0.
- Requester holds req while not granted (other port was granted last cycle) → granted next cycle; address accepted is the held value.
- Single port requesting every cycle for 10 cycles → 10 consecutive grants, 10 consecutive rvalid pulses with no bubbles.
